// File: rtl/key_event_decoder.sv
// SPACE hold-time jump encoder with a one-entry valid/ready jump buffer, duck level and restart pulse.
// Optional statistics counters are compiled in with KEY_EVENT_STATS_EN.
module key_event_decoder #(
    parameter int SHORT_MAX = 30,
    parameter int LONG_MAX  = 60,
    parameter int COOLDOWN  = 4
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       jump_ready,
    output logic       jump_valid,
    output logic       jump_long,
    output logic       jump_drop,
    output logic       duck,
    output logic       restart
`ifdef KEY_EVENT_STATS_EN
    ,
    output logic [7:0] jump_count,
    output logic [7:0] drop_count
`endif
);

    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic [7:0]      KEY_SPACE = 8'h20;
    localparam logic [7:0]      KEY_DOWN  = 8'h26;
    localparam logic [7:0]      KEY_ENTER = 8'h0d;
    localparam logic [5:0]      HOLD_LAST = 6'(LONG_MAX - 1);
    localparam logic [5:0]      SHORT_TH  = 6'(SHORT_MAX);
    localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHARGE,
        S_COOLDOWN
    } state_t;

    state_t          state_reg, state_next;
    logic [5:0]      hold_cnt_reg, hold_cnt_next;
    logic [CD_W-1:0] cd_cnt_reg, cd_cnt_next;
    logic [7:0]      prev_key_reg;

    logic valid_reg, valid_next;
    logic long_reg, long_next;
    logic drop_reg, drop_next;
    logic duck_reg, duck_next;
    logic restart_reg;

    logic space;
    logic restart_evt;
    logic fire;
    logic fire_long;
    logic accept;

    assign space       = (keycode == KEY_SPACE);
    assign restart_evt = (keycode == KEY_ENTER) && (prev_key_reg != KEY_ENTER);
    assign accept      = valid_reg && jump_ready;
    assign duck_next   = (keycode == KEY_DOWN) && (state_reg == S_IDLE);

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= S_IDLE;
            hold_cnt_reg <= '0;
            cd_cnt_reg   <= '0;
            prev_key_reg <= '0;
            valid_reg    <= 1'b0;
            long_reg     <= 1'b0;
            drop_reg     <= 1'b0;
            duck_reg     <= 1'b0;
            restart_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            cd_cnt_reg   <= cd_cnt_next;
            prev_key_reg <= keycode;
            valid_reg    <= valid_next;
            long_reg     <= long_next;
            drop_reg     <= drop_next;
            duck_reg     <= duck_next;
            restart_reg  <= restart_evt;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        cd_cnt_next   = cd_cnt_reg;
        fire          = 1'b0;
        fire_long     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (space) begin
                    state_next    = S_CHARGE;
                    hold_cnt_next = 6'd1;
                end
            end
            S_CHARGE: begin
                if (space && (hold_cnt_reg < HOLD_LAST)) begin
                    hold_cnt_next = hold_cnt_reg + 6'd1;
                end else begin
                    // Either auto-fire at the hold limit or fire on release.
                    fire          = 1'b1;
                    fire_long     = space || (hold_cnt_reg >= SHORT_TH);
                    state_next    = S_COOLDOWN;
                    hold_cnt_next = '0;
                    cd_cnt_next   = CD_LOAD;
                end
            end
            S_COOLDOWN: begin
                if (cd_cnt_reg != '0) begin
                    cd_cnt_next = cd_cnt_reg - CD_W'(1);
                end else if (!space) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (restart_evt) begin
            state_next    = S_IDLE;
            hold_cnt_next = '0;
            cd_cnt_next   = '0;
            fire          = 1'b0;
            fire_long     = 1'b0;
        end
    end

    // One-entry buffer: a fire overwrites only when the old entry leaves on the same edge.
    always_comb begin
        valid_next = valid_reg;
        long_next  = long_reg;
        drop_next  = 1'b0;
        if (restart_evt) begin
            valid_next = 1'b0;
        end else if (fire) begin
            if (!valid_reg || accept) begin
                valid_next = 1'b1;
                long_next  = fire_long;
            end else begin
                drop_next = 1'b1;
            end
        end else if (accept) begin
            valid_next = 1'b0;
        end
    end

    assign jump_valid = valid_reg;
    assign jump_long  = long_reg;
    assign jump_drop  = drop_reg;
    assign duck       = duck_reg;
    assign restart    = restart_reg;

`ifdef KEY_EVENT_STATS_EN
    logic [7:0] jump_cnt_reg;
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            jump_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else if (restart_evt) begin
            jump_cnt_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (accept && (jump_cnt_reg != 8'hff)) begin
                jump_cnt_reg <= jump_cnt_reg + 8'd1;
            end
            if (drop_next && (drop_cnt_reg != 8'hff)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign jump_count = jump_cnt_reg;
    assign drop_count = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: hold-length vector table plus hand sequences for auto-fire,
// cooldown, buffer drop, restart, duck and reset; transfers are scored against an expectation queue.
module tb_key_event_decoder;

    localparam int SHORT_MAX = 30;
    localparam int LONG_MAX  = 60;
    localparam int COOLDOWN  = 4;

    localparam logic [7:0] K_SPACE = 8'h20;
    localparam logic [7:0] K_DOWN  = 8'h26;
    localparam logic [7:0] K_ENTER = 8'h0d;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic       jump_ready;
    logic       jump_valid;
    logic       jump_long;
    logic       jump_drop;
    logic       duck;
    logic       restart;
`ifdef KEY_EVENT_STATS_EN
    logic [7:0] jump_count;
    logic [7:0] drop_count;
`endif

    key_event_decoder #(
        .SHORT_MAX(SHORT_MAX),
        .LONG_MAX (LONG_MAX),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .jump_ready(jump_ready),
        .jump_valid(jump_valid),
        .jump_long (jump_long),
        .jump_drop (jump_drop),
        .duck      (duck),
        .restart   (restart)
`ifdef KEY_EVENT_STATS_EN
        ,
        .jump_count(jump_count),
        .drop_count(drop_count)
`endif
    );

    always #5 frame_clk = ~frame_clk;

    int   checks   = 0;
    int   failures = 0;
    int   xfers    = 0;
    int   drops    = 0;
    int   restarts = 0;
    logic exp_q[$];
    logic exp_pop;

    typedef struct {
        int   hold;
        logic exp_long;
    } vec_t;
    vec_t vecs[6];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Press SPACE for hold edges and release; caller decides whether a transfer is expected.
    task automatic tap(input int hold);
        keycode = K_SPACE;
        repeat (hold) tick();
        keycode = 8'h00;
        tick();
    endtask

    // Transfers are scored on the negedge before the accepting edge.
    always @(negedge frame_clk) begin
        if (Reset === 1'b1) begin
            if (jump_valid && jump_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL xfer_unexpected: got transfer jump_long=%b required no transfer", jump_long);
                end else begin
                    exp_pop = exp_q.pop_front();
                    chk1("xfer_long", jump_long, exp_pop);
                    $display("xfer #%0d jump_long=%b", xfers, jump_long);
                end
            end
            if (jump_drop) drops++;
            if (restart) restarts++;
        end
    end

    int x0, d0, r0;

    initial begin
        vecs[0] = '{hold: 1,  exp_long: 1'b0};
        vecs[1] = '{hold: 5,  exp_long: 1'b0};
        vecs[2] = '{hold: 29, exp_long: 1'b0};
        vecs[3] = '{hold: 30, exp_long: 1'b1};
        vecs[4] = '{hold: 31, exp_long: 1'b1};
        vecs[5] = '{hold: 59, exp_long: 1'b1};

        Reset      = 1'b0;
        keycode    = 8'h00;
        jump_ready = 1'b0;
        repeat (3) tick();
        chkn("reset_outputs", int'({jump_valid, jump_long, jump_drop, duck, restart}), 0);
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chkn($sformatf("idle_outputs_%0d", i),
                 int'({jump_valid, jump_long, jump_drop, duck, restart}), 0);
        end

        // Hold-length table with control always ready.
        jump_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            keycode = K_SPACE;
            repeat (vecs[i].hold) tick();
            chk1($sformatf("v%0d_no_early_fire", i), jump_valid, 1'b0);
            keycode = 8'h00;
            exp_q.push_back(vecs[i].exp_long);
            tick();
            chk1($sformatf("v%0d_latency", i), jump_valid, 1'b1);
            chk1($sformatf("v%0d_long", i), jump_long, vecs[i].exp_long);
            tick();
            chk1($sformatf("v%0d_one_frame", i), jump_valid, 1'b0);
            repeat (COOLDOWN + 2) tick();
        end

        // Auto-fire on the LONG_MAX-th held edge, only once.
        x0 = xfers;
        keycode = K_SPACE;
        for (int i = 1; i <= 100; i++) begin
            if (i == LONG_MAX) exp_q.push_back(1'b1);
            tick();
            if (i == LONG_MAX - 1) chk1("auto_not_yet", jump_valid, 1'b0);
            if (i == LONG_MAX) begin
                chk1("auto_fire", jump_valid, 1'b1);
                chk1("auto_long", jump_long, 1'b1);
            end
        end
        chkn("auto_single", xfers - x0, 1);
        keycode = 8'h00;
        repeat (3) tick();

        // A press that starts during cooldown never charges.
        x0 = xfers;
        exp_q.push_back(1'b0);
        tap(5);
        keycode = 8'h00;
        repeat (2) tick();
        keycode = K_SPACE;
        repeat (3) tick();
        keycode = 8'h00;
        tick();
        chk1("cooldown_no_fire", jump_valid, 1'b0);
        repeat (4) tick();
        chkn("cooldown_xfers", xfers - x0, 1);

        // Buffer full: second jump dropped, first kept.
        jump_ready = 1'b0;
        exp_q.push_back(1'b0);
        tap(5);
        chk1("buf_first_valid", jump_valid, 1'b1);
        repeat (10) tick();
        d0 = drops;
        tap(35);
        chk1("drop_pulse", jump_drop, 1'b1);
        chk1("drop_keeps_valid", jump_valid, 1'b1);
        chk1("drop_keeps_long", jump_long, 1'b0);
        tick();
        chk1("drop_one_frame", jump_drop, 1'b0);
        chkn("drop_count_tb", drops - d0, 1);
        jump_ready = 1'b1;
        tick();
        chk1("drop_drained", jump_valid, 1'b0);
        repeat (6) tick();

        // ENTER held while charging aborts the charge.
        r0 = restarts;
        x0 = xfers;
        keycode = K_SPACE;
        repeat (10) tick();
        keycode = K_ENTER;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) chk1("restart_pulse", restart, 1'b1);
            if (i == 2) chk1("restart_one_frame", restart, 1'b0);
            chk1($sformatf("restart_no_jump_%0d", i), jump_valid, 1'b0);
        end
        keycode = 8'h00;
        repeat (6) tick();
        chkn("restart_once", restarts - r0, 1);
        chkn("restart_xfers", xfers - x0, 0);

        // Restart clears a pending entry without a drop.
        jump_ready = 1'b0;
        tap(5);
        chk1("pend_valid", jump_valid, 1'b1);
        repeat (6) tick();
        keycode = K_ENTER;
        tick();
        chk1("restart_clears_valid", jump_valid, 1'b0);
        chk1("restart_no_drop", jump_drop, 1'b0);
        keycode = 8'h00;
        jump_ready = 1'b1;
        tick();

        // Duck only in IDLE.
        keycode = K_DOWN;
        tick();
        chk1("duck_idle", duck, 1'b1);
        keycode = 8'h00;
        tick();
        chk1("duck_release", duck, 1'b0);
        keycode = K_SPACE;
        repeat (3) tick();
        keycode = K_DOWN;
        exp_q.push_back(1'b0);
        tick();
        chk1("duck_charging", duck, 1'b0);
        chk1("down_releases_jump", jump_valid, 1'b1);
        for (int i = 1; i <= COOLDOWN; i++) begin
            tick();
            chk1($sformatf("duck_cooldown_%0d", i), duck, 1'b0);
        end
        tick();
        chk1("duck_after_cooldown", duck, 1'b1);
        keycode = 8'h00;
        tick();

        // Asynchronous reset mid-charge drops the charge silently.
        x0 = xfers;
        keycode = K_SPACE;
        repeat (10) tick();
        Reset = 1'b0;
        #1;
        chkn("async_reset", int'({jump_valid, jump_long, jump_drop, duck, restart}), 0);
        keycode = 8'h00;
        tick();
        Reset = 1'b1;
        repeat (3) tick();
        chk1("reset_no_jump", jump_valid, 1'b0);
        chkn("reset_xfers", xfers - x0, 0);

`ifdef KEY_EVENT_STATS_EN
        keycode = K_ENTER;
        tick();
        keycode = 8'h00;
        tick();
        chkn("stats_cleared", int'({jump_count, drop_count}), 0);
        jump_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(1'b0);
            tap(5);
            repeat (COOLDOWN + 2) tick();
        end
        jump_ready = 1'b0;
        exp_q.push_back(1'b0);
        tap(5);
        repeat (COOLDOWN + 2) tick();
        tap(5);
        repeat (COOLDOWN + 2) tick();
        jump_ready = 1'b1;
        repeat (2) tick();
        chkn("stats_jump_count", int'(jump_count), 3);
        chkn("stats_drop_count", int'(drop_count), 1);
        keycode = K_ENTER;
        tick();
        keycode = 8'h00;
        tick();
        chkn("stats_restart_jump", int'(jump_count), 0);
        chkn("stats_restart_drop", int'(drop_count), 0);
`endif

        repeat (4) tick();
        chkn("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
